// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, pipeline-register controls and status between datapath and pipeline_ctrl
interface pipeline_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       mem_wb_bubble;
  logic [1:0] state;
  logic       mem_timeout;
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, mem_wb_bubble,
           state, mem_timeout
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, mem_wb_bubble,
           state, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage hazard/stall controller with memory-wait timeout; PIPELINE_CTRL_PERF_CNT_EN enables stall/flush counters
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
  // ctl bits: {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, mem_wb_bubble}
  localparam logic [6:0] GO       = 7'b1111000;
  localparam logic [6:0] FREEZE   = 7'b0000001;
  localparam logic [6:0] BR_FLUSH = 7'b1111110;
  localparam logic [6:0] LU_STALL = 7'b0011010;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);
  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] ctl;
  logic       load_use, mem_stall;
  assign mem_stall = bus.dmem_req && !bus.dmem_ready;
  assign load_use  = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                     (bus.ex_rd == bus.id_rs1 || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
  assign {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
          bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble} = ctl;
  assign bus.state       = state_q;
  assign bus.mem_timeout = rst_n && state_q == ERROR;
  // state and wait counter registers; reset aborts any wait
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  // next state and pipeline controls; reset forces FREEZE whatever the state
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = GO;
    case (state_q)
      RUN: begin
        ctl = mem_stall ? FREEZE : bus.branch_taken ? BR_FLUSH : load_use ? LU_STALL : GO;
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        ctl = bus.dmem_ready ? GO : FREEZE;
        if (bus.dmem_ready) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_MAX) state_d = ERROR;
        else wait_d = wait_q + 8'd1;
      end
      ERROR: ctl = FREEZE;
      default: begin
        ctl     = FREEZE;
        state_d = RUN;
      end
    endcase
    if (!rst_n) ctl = FREEZE;
  end
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  // saturating counters of stalled-PC cycles and front-end flushes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl[6] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (ctl[2] && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a cycle-level reference model
module tb_pipeline_ctrl;
  localparam int TO = 4;
  localparam int CW = 16;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] GO = 7'b1111000, FRZ = 7'b0000001, BRF = 7'b1111110, LUS = 7'b0011010;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipeline_ctrl_if bus ();
  logic [CW-1:0] stall_cnt, flush_cnt;
  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  int n_cmp = 0, n_bad = 0;
  int m_state = 0, m_frozen = 0, m_stall = 0, m_flush = 0;
  wire [6:0] ctl = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                    bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble};
  wire [9:0] obs = {bus.state, bus.mem_timeout, ctl};
  wire [2*CW-1:0] cnts = {stall_cnt, flush_cnt};

  function automatic logic [6:0] exp_ctl();
    logic lu;
    lu = bus.ex_mem_read && bus.ex_rd != 0 &&
         (bus.ex_rd == bus.id_rs1 || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
    if (!rst_n || m_state == 2) return FRZ;
    if (m_state == 1) return bus.dmem_ready ? GO : FRZ;
    if (bus.dmem_req && !bus.dmem_ready) return FRZ;
    return bus.branch_taken ? BRF : lu ? LUS : GO;
  endfunction

  function automatic logic [9:0] exp_all();
    return {2'(m_state), rst_n && m_state == 2, exp_ctl()};
  endfunction

  function automatic logic [2*CW-1:0] exp_cnts();
    return PERF ? {CW'(m_stall), CW'(m_flush)} : '0;
  endfunction

  task automatic drive(input logic [4:0] rs1, rs2, input logic u, input logic [4:0] rd,
                       input logic mr, br, rq, ry);
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_uses_rs2 = u; bus.ex_rd = rd;
    bus.ex_mem_read = mr; bus.branch_taken = br; bus.dmem_req = rq; bus.dmem_ready = ry;
    #1;
  endtask

  task automatic tick();
    logic [6:0] e;
    e = exp_ctl();
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[6]) m_stall++;
      if (e[2]) m_flush++;
      if (m_state == 0 && bus.dmem_req && !bus.dmem_ready) begin
        m_state = 1; m_frozen = 1;
      end else if (m_state == 1) begin
        if (bus.dmem_ready) begin
          m_state = 0; m_frozen = 0;
        end else begin
          m_frozen++;
          if (m_frozen == TO) m_state = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(5'd1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (obs !== {2'b00, 1'b0, FRZ}) begin
        n_bad++; $display("FAIL reset_outputs: got %b want %b", obs, {2'b00, 1'b0, FRZ});
      end
      n_cmp++;
      if (cnts !== '0) begin
        n_bad++; $display("FAIL reset_counters: got %h want 0", cnts);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [4:0] rs1, rs2; logic u; logic [4:0] rd; logic mr, br; logic [6:0] e;
  } vec_t;

  task automatic test_hazards();
    vec_t v [8];
    v[0] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, LUS};
    v[1] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, GO};
    v[2] = '{5'd0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, GO};
    v[3] = '{5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, LUS};
    v[4] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, GO};
    v[5] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, BRF};
    v[6] = '{5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, BRF};
    v[7] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, BRF};
    for (int i = 0; i < 8; i++) begin
      drive(v[i].rs1, v[i].rs2, v[i].u, v[i].rd, v[i].mr, v[i].br, 1'b0, 1'($urandom_range(1)));
      n_cmp++;
      if (obs !== {2'b00, 1'b0, v[i].e}) begin
        n_bad++; $display("FAIL hazard_vec%0d: got %b want %b", i, obs, {2'b00, 1'b0, v[i].e});
      end
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (cnts !== exp_cnts()) begin
      n_bad++; $display("FAIL hazard_counters: got %h want %h", cnts, exp_cnts());
    end
  endtask

  task automatic test_mem_wait();
    int s0;
    logic [1:0] st [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
    s0 = m_stall;
    for (int i = 0; i < 4; i++) begin
      drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'(i > 0), 1'b1, 1'(i == 3));
      n_cmp++;
      if (obs !== {st[i], 1'b0, (i == 3) ? GO : FRZ}) begin
        n_bad++; $display("FAIL mem_wait_cyc%0d: got %b want %b", i, obs, {st[i], 1'b0, (i == 3) ? GO : FRZ});
      end
      tick();
    end
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== {2'b00, 1'b0, BRF}) begin
      n_bad++; $display("FAIL mem_wait_held_branch: got %b want %b", obs, {2'b00, 1'b0, BRF});
    end
    n_cmp++;
    if (stall_cnt !== (PERF ? CW'(s0 + 3) : CW'(0))) begin
      n_bad++; $display("FAIL mem_wait_stall_cnt: got %0d want %0d", stall_cnt, PERF ? s0 + 3 : 0);
    end
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 7; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, (i < 4) ? 1'b0 : 1'($urandom_range(1)));
      n_cmp++;
      if (obs !== {(i == 0) ? 2'b00 : (i < 4) ? 2'b01 : 2'b10, i >= 4, FRZ}) begin
        n_bad++; $display("FAIL timeout_cyc%0d: got %b want %b", i, obs,
                          {(i == 0) ? 2'b00 : (i < 4) ? 2'b01 : 2'b10, i >= 4, FRZ});
      end
      tick();
    end
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (obs !== {2'b10, 1'b0, FRZ}) begin
      n_bad++; $display("FAIL timeout_in_reset: got %b want %b", obs, {2'b10, 1'b0, FRZ});
    end
    tick();
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({obs, cnts} !== {2'b00, 1'b0, GO, {2*CW{1'b0}}}) begin
      n_bad++; $display("FAIL timeout_after_reset: got %b/%h want %b/0", obs, cnts, {2'b00, 1'b0, GO});
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(99) >= 2);
      drive(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
            1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
            ($urandom_range(2) == 0));
      n_cmp++;
      if (obs !== exp_all()) begin
        n_bad++; $display("FAIL random_ctl cyc%0d: got %b want %b", i, obs, exp_all());
      end
      n_cmp++;
      if (cnts !== exp_cnts()) begin
        n_bad++; $display("FAIL random_cnt cyc%0d: got %h want %h", i, cnts, exp_cnts());
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hazards();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum MEM_WAIT cycles before the timeout error; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: performance counter width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-006 id_uses_rs2  in  1  instruction in ID reads rs2 as an ALU operand (0 for I-type, loads, and store data).
REQ-007 ex_rd  in  5  destination of the instruction in ID/EX; ex_mem_read  in  1  that instruction is a load.
REQ-008 branch_taken  in  1  EX-stage branch/jump resolved taken this cycle.
REQ-009 dmem_req  in  1  MEM stage holds a load/store; dmem_ready  in  1  data memory completes the access this cycle.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register-enable per pipeline register.
REQ-011 if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  insert NOP into the named register.
REQ-012 state  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR; mem_timeout  out  1  high only in ERROR.
REQ-013 stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Configuration).

Function
REQ-014 Default output set "GO" is: all *_write=1, all flush/bubble=0.
REQ-015 Output set "FREEZE" is: pc_write, if_id_write, id_ex_write, ex_mem_write all 0, mem_wb_bubble=1, if_id_flush=0, id_ex_bubble=0.
REQ-016 Outputs are combinational from state and inputs; wait_cnt (8 bits) and the counters are registered.
REQ-017 RUN, mem stall (dmem_req=1, dmem_ready=0): drive FREEZE; next state MEM_WAIT; wait_cnt<=1.
REQ-018 RUN, no mem stall, branch_taken=1: drive GO, except if_id_flush=1 and id_ex_bubble=1; stay RUN; branch overrides load-use.
REQ-019 RUN, load-use: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 or (id_uses_rs2 and ex_rd==id_rs2)) -> pc_write=0, if_id_write=0, id_ex_bubble=1, others GO.
REQ-020 Priority within RUN is mem stall > branch flush > load-use > GO.
REQ-021 MEM_WAIT, dmem_ready=1: drive GO (branch/load-use not evaluated this cycle); next RUN; wait_cnt<=0.
REQ-022 MEM_WAIT, dmem_ready=0, wait_cnt<TIMEOUT-1: drive FREEZE; wait_cnt<=wait_cnt+1.
REQ-023 MEM_WAIT, dmem_ready=0, wait_cnt==TIMEOUT-1: drive FREEZE; next ERROR.
REQ-024 ERROR: drive FREEZE, mem_timeout=1; exit only by reset; dmem_ready ignored.
REQ-025 branch_taken or hazard arriving during MEM_WAIT is held by the frozen pipeline and acted on in the first RUN cycle after release.
REQ-026 dmem_req=0 in RUN never enters MEM_WAIT, regardless of dmem_ready.

Reset
REQ-027 On a rising edge with rst_n=0: state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0.
REQ-028 In any cycle where rst_n=0, outputs equal FREEZE with mem_timeout=0, regardless of state.
REQ-029 Reset asserted in MEM_WAIT or ERROR aborts the wait; the first cycle after release is RUN.

Configuration
REQ-030 Macro PIPELINE_CTRL_PERF_CNT_EN defined: stall_cnt +1 every cycle with rst_n=1 and pc_write=0; flush_cnt +1 every cycle with if_id_flush=1; both saturate at all-ones.
REQ-031 Macro undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist; all other behaviour is identical.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; ex_rd=0 under the same conditions -> GO.
REQ-033 ex_rd=7, id_rs2=7, id_uses_rs2=0 -> GO; with id_uses_rs2=1 -> load-use stall.
REQ-034 Load-use condition plus branch_taken=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1.
REQ-035 dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 FREEZE cycles (RUN, then MEM_WAIT x2), GO on cycle 4, state RUN; with the macro defined, stall_cnt=3.
REQ-036 TIMEOUT=4, dmem_ready held low -> ERROR entered after 4 FREEZE cycles, mem_timeout=1 held; rst_n=0 for one cycle -> state 00, counters 0.
